bht_update_sched: RTL and testbench

Write-port scheduler for the branch history table. It captures branch resolutions from EX in a small FIFO so that they survive write-port backpressure. It drains them one per cycle onto the single BHT write port and, on a fence.i-style invalidate request, takes the port over to sweep-clear every entry. It sits between the EX stage and the BHT and also gates BHT prediction while the table is being invalidated.

---
 rtl/bht_update_sched.sv | 170 +++++++++++++++++
 tb/tb_bht_update_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_sched.sv
// Write-port scheduler for the branch history table. Buffers EX branch
// resolutions in a small FIFO, drains them one per cycle onto the BHT write
// port, and on an invalidate request sweeps every entry clear while
// suppressing prediction.
module bht_update_sched #(
  parameter int ADDR_WIDTH    = 32,
  parameter int HISTORY_DEPTH = 512,
  parameter int FIFO_DEPTH    = 4,
  localparam int IDX_W        = $clog2(HISTORY_DEPTH),
  localparam int TAG_W        = ADDR_WIDTH - IDX_W - 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CACHE_READY,
  input  logic                  CACHE_READY_DATA,
  input  logic                  BRANCH,
  input  logic                  BRANCH_TAKEN,
  input  logic                  RETURN,
  input  logic                  FLUSH,
  input  logic [ADDR_WIDTH-1:0] EX_PC,
  input  logic [ADDR_WIDTH-1:0] BRANCH_ADDR,
  input  logic                  INVALIDATE,
  input  logic                  WR_READY,
  output logic                  WR_EN,
  output logic                  WR_CLEAR,
  output logic [IDX_W-1:0]      WR_INDEX,
  output logic [TAG_W-1:0]      WR_TAG,
  output logic [ADDR_WIDTH-1:0] WR_TARGET,
  output logic                  WR_TAKEN,
  output logic                  WR_RETURN,
  output logic                  INV_BUSY,
  output logic                  PRD_ENABLE,
  output logic                  STALL,
  output logic [31:0]           DROP_CNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HISTORY_DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t state, next_state;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [IDX_W-1:0] sweep_idx;
  logic [31:0]      drop_cnt;

  logic [IDX_W-1:0]      q_index  [FIFO_DEPTH];
  logic [TAG_W-1:0]      q_tag    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] q_target [FIFO_DEPTH];
  logic                  q_taken  [FIFO_DEPTH];
  logic                  q_return [FIFO_DEPTH];

  logic advance, capture;
  logic push, pop, drop, clear_q, sweep_step;
  logic unused_pc_bits;

  // Saturating increment so a long-running drop counter never wraps to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign advance        = CACHE_READY & CACHE_READY_DATA;
  assign capture        = advance & BRANCH & ~FLUSH;
  assign unused_pc_bits = ^EX_PC[1:0];

  assign INV_BUSY   = (state == SWEEP);
  assign PRD_ENABLE = ~INV_BUSY;
  assign STALL      = (count == FULL_CNT);
  assign DROP_CNT   = drop_cnt;

  // Next-state, write-port muxing and FIFO push/pop/drop decisions.
  always_comb begin
    next_state = state;
    WR_EN      = 1'b0;
    WR_CLEAR   = 1'b0;
    WR_INDEX   = '0;
    WR_TAG     = '0;
    WR_TARGET  = '0;
    WR_TAKEN   = 1'b0;
    WR_RETURN  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    drop       = 1'b0;
    clear_q    = 1'b0;
    sweep_step = 1'b0;
    if (state == SWEEP) begin
      // Sweep owns the port; any capture is lost and a repeat invalidate
      // simply merges into the sweep already running.
      WR_EN    = 1'b1;
      WR_CLEAR = 1'b1;
      WR_INDEX = sweep_idx;
      drop     = capture;
      if (WR_READY) begin
        sweep_step = 1'b1;
        if (sweep_idx == LAST_IDX) next_state = IDLE;
      end
    end else begin
      // Fields are gated by occupancy so an empty queue shows all zeros.
      if (count != '0) begin
        WR_EN     = 1'b1;
        WR_INDEX  = q_index[rd_ptr];
        WR_TAG    = q_tag[rd_ptr];
        WR_TARGET = q_target[rd_ptr];
        WR_TAKEN  = q_taken[rd_ptr];
        WR_RETURN = q_return[rd_ptr];
      end
      pop = (count != '0) & WR_READY;
      if (INVALIDATE) begin
        // The head write still completes this cycle if accepted; everything
        // queued behind it, and any capture now, is discarded.
        next_state = SWEEP;
        clear_q    = 1'b1;
        drop       = capture;
      end else if (capture) begin
        if ((count != FULL_CNT) || pop) push = 1'b1;
        else                            drop = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // FIFO occupancy, pointers, sweep index and drop counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      sweep_idx <= '0;
      drop_cnt  <= '0;
    end else begin
      if (clear_q) begin
        count     <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        sweep_idx <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (sweep_step) sweep_idx <= sweep_idx + 1'b1;
      end
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // FIFO payload storage; only read while occupied, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_index[wr_ptr]  <= EX_PC[IDX_W+1:2];
      q_tag[wr_ptr]    <= EX_PC[ADDR_WIDTH-1:IDX_W+2];
      q_target[wr_ptr] <= BRANCH_ADDR;
      q_taken[wr_ptr]  <= BRANCH_TAKEN;
      q_return[wr_ptr] <= RETURN;
    end
  end

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed bench for bht_update_sched: table-driven FIFO/drain vectors plus
// hand-written sweep, toggled-ready sweep and asynchronous reset sequences.
module tb_bht_update_sched;

  localparam int AW = 32;
  localparam int HD = 512;
  localparam int FD = 4;
  localparam int IW = 9;
  localparam int TW = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          cache_ready, cache_ready_data, branch, branch_taken, ret, flush;
  logic [AW-1:0] ex_pc, branch_addr;
  logic          invalidate, wr_ready;
  logic          wr_en, wr_clear, wr_taken, wr_return, inv_busy, prd_enable, stall;
  logic [IW-1:0] wr_index;
  logic [TW-1:0] wr_tag;
  logic [AW-1:0] wr_target;
  logic [31:0]   drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bht_update_sched #(.ADDR_WIDTH(AW), .HISTORY_DEPTH(HD), .FIFO_DEPTH(FD)) dut (
    .CLK(clk), .RST(rst),
    .CACHE_READY(cache_ready), .CACHE_READY_DATA(cache_ready_data),
    .BRANCH(branch), .BRANCH_TAKEN(branch_taken), .RETURN(ret), .FLUSH(flush),
    .EX_PC(ex_pc), .BRANCH_ADDR(branch_addr),
    .INVALIDATE(invalidate), .WR_READY(wr_ready),
    .WR_EN(wr_en), .WR_CLEAR(wr_clear), .WR_INDEX(wr_index), .WR_TAG(wr_tag),
    .WR_TARGET(wr_target), .WR_TAKEN(wr_taken), .WR_RETURN(wr_return),
    .INV_BUSY(inv_busy), .PRD_ENABLE(prd_enable), .STALL(stall), .DROP_CNT(drop_cnt)
  );

  typedef struct {
    logic        cr, crd, br, fl, tk, rt, rdy;
    logic [31:0] pc, tgt;
    logic [127:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic logic [127:0] mk(input logic en, clr, input logic [IW-1:0] idx,
                                      input logic [TW-1:0] tag, input logic [31:0] tgt,
                                      input logic tk, rt, busy, prd, stl,
                                      input logic [31:0] drop);
    return {27'b0, en, clr, idx, tag, tgt, tk, rt, busy, prd, stl, drop};
  endfunction

  // Expected output word for a pending queued write.
  function automatic logic [127:0] mkw(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                                       input logic [31:0] tgt, input logic tk, rt, stl,
                                       input logic [31:0] drop);
    return mk(1'b1, 1'b0, idx, tag, tgt, tk, rt, 1'b0, 1'b1, stl, drop);
  endfunction

  // Expected output word for an idle, empty port.
  function automatic logic [127:0] mki(input logic stl, input logic [31:0] drop);
    return mk(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, stl, drop);
  endfunction

  function automatic logic [127:0] snap();
    return {27'b0, wr_en, wr_clear, wr_index, wr_tag, wr_target, wr_taken, wr_return,
            inv_busy, prd_enable, stall, drop_cnt};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, crd, br, fl, tk, rt, rdy, inv,
                       input logic [31:0] pc, tgt);
    cache_ready      = cr;
    cache_ready_data = crd;
    branch           = br;
    flush            = fl;
    branch_taken     = tk;
    ret              = rt;
    wr_ready         = rdy;
    invalidate       = inv;
    ex_pc            = pc;
    branch_addr      = tgt;
  endtask

  task automatic addv(input logic cr, crd, br, fl, tk, rt, rdy,
                      input logic [31:0] pc, tgt, input logic [127:0] exp);
    vec_t v;
    v.cr = cr; v.crd = crd; v.br = br; v.fl = fl; v.tk = tk; v.rt = rt; v.rdy = rdy;
    v.pc = pc; v.tgt = tgt; v.exp = exp;
    vt.push_back(v);
  endtask

  // Runs one sweep from its first cycle; captures at cycles 10/20/30 and a
  // repeat invalidate at cycle 200. Returns busy cycles, accepted clears and
  // cycles whose write fields were wrong.
  task automatic sweep_run(input bit toggle, output int busy, output int acc, output int bad);
    logic rdy;
    busy = 0; acc = 0; bad = 0;
    while (inv_busy && busy < 3000) begin
      if (!(wr_en && wr_clear && wr_index == acc[IW-1:0] && wr_tag == '0 &&
            wr_target == '0 && !wr_taken && !wr_return && !prd_enable)) bad++;
      busy++;
      rdy = toggle ? (busy % 2 == 0) : 1'b1;
      drive(1, 1, (busy == 10 || busy == 20 || busy == 30), 0, 1, 0, rdy,
            (busy == 200), 32'h0000_1044, 32'h0000_2000);
      if (rdy) acc++;
      @(negedge clk);
    end
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    int busy, acc, bad, g;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("reset_state", snap(), mki(0, 0));

    // A: pc 0x100  B: pc 0xFFFFFFFC  C: pc 0x800  D: pc 0x055E6C8C  J: pc 0x1044
    addv(1,1,1,0,1,0,1, 32'h0000_1044, 32'h0000_2000, mkw(9'h011, 21'h2, 32'h2000, 1, 0, 0, 0));
    addv(1,1,0,0,0,0,1, 32'h0, 32'h0, mki(0, 0));
    addv(1,1,1,1,1,0,1, 32'h0000_1044, 32'h0000_2000, mki(0, 0));
    addv(0,1,1,0,1,0,1, 32'h0000_1044, 32'h0000_2000, mki(0, 0));
    addv(1,0,1,0,1,0,1, 32'h0000_1044, 32'h0000_2000, mki(0, 0));
    addv(1,1,1,0,0,1,0, 32'h0000_0100, 32'h0000_0300, mkw(9'h040, 21'h0, 32'h300, 0, 1, 0, 0));
    addv(1,1,1,0,1,0,0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, mkw(9'h040, 21'h0, 32'h300, 0, 1, 0, 0));
    addv(1,1,1,0,1,1,0, 32'h0000_0800, 32'h0000_0004, mkw(9'h040, 21'h0, 32'h300, 0, 1, 0, 0));
    addv(1,1,1,0,0,0,0, 32'h055E_6C8C, 32'h1234_5678, mkw(9'h040, 21'h0, 32'h300, 0, 1, 1, 0));
    addv(1,1,1,0,1,0,0, 32'h0000_1044, 32'h0000_2000, mkw(9'h040, 21'h0, 32'h300, 0, 1, 1, 1));
    addv(1,1,0,0,0,0,1, 32'h0, 32'h0, mkw(9'h1FF, 21'h1FFFFF, 32'hDEADBEEF, 1, 0, 0, 1));
    addv(1,1,0,0,0,0,1, 32'h0, 32'h0, mkw(9'h000, 21'h1, 32'h4, 1, 1, 0, 1));
    addv(1,1,0,0,0,0,1, 32'h0, 32'h0, mkw(9'h123, 21'h0ABCD, 32'h12345678, 0, 0, 0, 1));
    addv(1,1,0,0,0,0,1, 32'h0, 32'h0, mki(0, 1));
    addv(1,1,1,0,0,0,0, 32'h055E_6C8C, 32'h1234_5678, mkw(9'h123, 21'h0ABCD, 32'h12345678, 0, 0, 0, 1));
    addv(1,1,1,0,1,1,0, 32'h0000_0800, 32'h0000_0004, mkw(9'h123, 21'h0ABCD, 32'h12345678, 0, 0, 0, 1));
    addv(1,1,1,0,1,0,0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, mkw(9'h123, 21'h0ABCD, 32'h12345678, 0, 0, 0, 1));
    addv(1,1,1,0,0,1,0, 32'h0000_0100, 32'h0000_0300, mkw(9'h123, 21'h0ABCD, 32'h12345678, 0, 0, 1, 1));
    addv(1,1,1,0,1,0,1, 32'h0000_1044, 32'h0000_2000, mkw(9'h000, 21'h1, 32'h4, 1, 1, 1, 1));
    addv(1,1,0,0,0,0,1, 32'h0, 32'h0, mkw(9'h1FF, 21'h1FFFFF, 32'hDEADBEEF, 1, 0, 0, 1));
    addv(1,1,0,0,0,0,1, 32'h0, 32'h0, mkw(9'h040, 21'h0, 32'h300, 0, 1, 0, 1));
    addv(1,1,0,0,0,0,1, 32'h0, 32'h0, mkw(9'h011, 21'h2, 32'h2000, 1, 0, 0, 1));
    addv(1,1,0,0,0,0,1, 32'h0, 32'h0, mki(0, 1));

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].cr, vt[i].crd, vt[i].br, vt[i].fl, vt[i].tk, vt[i].rt, vt[i].rdy, 0,
            vt[i].pc, vt[i].tgt);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), snap(), vt[i].exp);
    end

    // Sweep with two queued updates and a capture in the invalidate cycle.
    @(negedge clk) drive(1, 1, 1, 0, 0, 1, 0, 0, 32'h0000_0100, 32'h0000_0300);
    @(negedge clk) drive(1, 1, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'hDEAD_BEEF);
    @(negedge clk) check("two_queued", snap(), mkw(9'h040, 21'h0, 32'h300, 0, 1, 0, 1));
    drive(1, 1, 1, 0, 1, 1, 1, 1, 32'h0000_0800, 32'h0000_0004);
    @(posedge clk);
    #1 check("sweep_start", snap(), mk(1, 1, '0, '0, '0, 0, 0, 1, 0, 0, 2));
    @(negedge clk);
    sweep_run(1'b0, busy, acc, bad);
    check("sweep_busy_cycles", 128'(busy), 128'(512));
    check("sweep_accepted", 128'(acc), 128'(512));
    check("sweep_fields", 128'(bad), 128'(0));
    check("sweep_end", snap(), mki(0, 5));

    // Sweep with WR_READY alternating 0,1.
    drive(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    sweep_run(1'b1, busy, acc, bad);
    check("toggle_busy_cycles", 128'(busy), 128'(1024));
    check("toggle_accepted", 128'(acc), 128'(512));
    check("toggle_fields", 128'(bad), 128'(0));
    check("toggle_end", snap(), mki(0, 8));

    // Asynchronous reset in the middle of a sweep.
    drive(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    g = 0;
    while (wr_index != 9'd100 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("rst_reach_idx100", 128'({inv_busy, wr_index}), 128'({1'b1, 9'd100}));
    #2 rst = 1'b1;
    #1 check("async_reset", snap(), mki(0, 0));
    @(negedge clk) rst = 1'b0;
    @(negedge clk) check("after_release", snap(), mki(0, 0));
    drive(1, 1, 1, 0, 1, 0, 1, 0, 32'h0000_1044, 32'h0000_2000);
    @(posedge clk);
    #1 check("post_reset_capture", snap(), mkw(9'h011, 21'h2, 32'h2000, 1, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
